// File: rtl/text_mem_arbiter.sv
// Round-robin arbiter sharing the Video_Driver character-RAM port between two requesters.
// Define TMA_PROTECT_EN to block port-0 writes into the protected status row.
module text_mem_arbiter #(
    parameter int unsigned       ADDR_W    = 11,
    parameter int unsigned       DATA_W    = 16,
    parameter int unsigned       RD_LAT    = 1,
    parameter logic [ADDR_W-1:0] PROT_BASE = 11'h780
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              we,
    input  logic [DATA_W-1:0] ret_data,
    output logic              prot_hit
);

`ifdef TMA_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_gnt0, r_gnt1, r_we;
    logic              r_rvalid0, r_rvalid1;
    logic              r_prot_hit;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] r_rdata0, r_rdata1;
    logic [RD_LAT-1:0] r_tag_v;
    logic [RD_LAT-1:0] r_tag_p;

    logic              w_grant;
    logic              w_sel;
    logic              w_req_we;
    logic              w_block;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // On a tie the port that did not win last time gets the slot.
    assign w_grant  = (r_state == S_IDLE) && (req0 || req1);
    assign w_sel    = (req0 && req1) ? ~r_last : req1;
    assign w_addr   = w_sel ? addr1  : addr0;
    assign w_wdata  = w_sel ? wdata1 : wdata0;
    assign w_req_we = w_sel ? we1    : we0;
    assign w_block  = PROT_EN && !w_sel && we0 && (addr0 >= PROT_BASE);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_we       <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_prot_hit <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
            r_tag_v    <= '0;
            r_tag_p    <= '0;
        end else begin
            // Tag pipeline: stage 0 is loaded on the edge that registers mem_addr.
            r_tag_v[0] <= w_grant && !w_req_we;
            r_tag_p[0] <= w_sel;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                r_tag_v[k] <= r_tag_v[k-1];
                r_tag_p[k] <= r_tag_p[k-1];
            end
            r_rvalid0 <= r_tag_v[RD_LAT-1] && !r_tag_p[RD_LAT-1];
            r_rvalid1 <= r_tag_v[RD_LAT-1] &&  r_tag_p[RD_LAT-1];
            if (r_tag_v[RD_LAT-1] && !r_tag_p[RD_LAT-1]) r_rdata0 <= ret_data;
            if (r_tag_v[RD_LAT-1] &&  r_tag_p[RD_LAT-1]) r_rdata1 <= ret_data;

            case (r_state)
                S_IDLE: begin
                    r_gnt0 <= w_grant && !w_sel;
                    r_gnt1 <= w_grant &&  w_sel;
                    r_we   <= w_grant && w_req_we && !w_block;
                    if (w_grant) begin
                        r_mem_addr <= w_addr;
                        r_mem_data <= w_wdata;
                        r_last     <= w_sel;
                        r_state    <= S_HOLD;
                        if (w_block) r_prot_hit <= 1'b1;
                    end
                end
                S_HOLD: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign we       = r_we;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign prot_hit = PROT_EN && r_prot_hit;

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Bench for text_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) sharing stimulus,
// checked against a transaction-level arbitration/RAM model.
module tb_text_mem_arbiter;

`ifdef TMA_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        int          due;
        int          port;
        logic [15:0] data;
    } pend_t;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [10:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;

    logic        gnt0_o [2];
    logic        gnt1_o [2];
    logic        rvalid0_o [2];
    logic        rvalid1_o [2];
    logic        we_o [2];
    logic        prot_o [2];
    logic [15:0] rdata0_o [2];
    logic [15:0] rdata1_o [2];
    logic [15:0] mem_data_o [2];
    logic [15:0] ret_data_i [2];
    logic [10:0] mem_addr_o [2];

    bit   [15:0] ram0 [2048];
    bit   [15:0] ram1 [2048];
    bit   [15:0] mmem [2048];
    logic [15:0] d1_1, d1_2;
    logic        pre_en = 1'b0;
    logic [10:0] pre_a;
    logic [15:0] pre_d;

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_edge  = 0;
    int          next_free = 0;
    int          m_last  = 1;
    int          last_gnt = 2;
    bit          e_gnt0, e_gnt1, e_we, e_prot;
    logic [10:0] e_maddr;
    logic [15:0] e_mdata;
    bit          e_rv0 [2];
    bit          e_rv1 [2];
    logic [15:0] e_rd0 [2];
    logic [15:0] e_rd1 [2];
    pend_t       pq0 [$];
    pend_t       pq1 [$];

    always #5 sys_clk = ~sys_clk;

    text_mem_arbiter #(.ADDR_W(11), .DATA_W(16), .RD_LAT(1), .PROT_BASE(11'h780)) u_dut_l1 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_o[0]), .rvalid0(rvalid0_o[0]), .rdata0(rdata0_o[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_o[0]), .rvalid1(rvalid1_o[0]), .rdata1(rdata1_o[0]),
        .mem_addr(mem_addr_o[0]), .mem_data(mem_data_o[0]), .we(we_o[0]),
        .ret_data(ret_data_i[0]), .prot_hit(prot_o[0])
    );

    text_mem_arbiter #(.ADDR_W(11), .DATA_W(16), .RD_LAT(3), .PROT_BASE(11'h780)) u_dut_l3 (
        .sys_clk(sys_clk), .sys_rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0_o[1]), .rvalid0(rvalid0_o[1]), .rdata0(rdata0_o[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1_o[1]), .rvalid1(rvalid1_o[1]), .rdata1(rdata1_o[1]),
        .mem_addr(mem_addr_o[1]), .mem_data(mem_data_o[1]), .we(we_o[1]),
        .ret_data(ret_data_i[1]), .prot_hit(prot_o[1])
    );

    // Character RAM models: data readable in the cycle after mem_addr for latency 1,
    // and delayed two further stages for latency 3.
    always @(posedge sys_clk) begin
        if (pre_en) begin
            ram0[pre_a] <= pre_d;
            ram1[pre_a] <= pre_d;
        end
        if (we_o[0]) ram0[mem_addr_o[0]] <= mem_data_o[0];
        if (we_o[1]) ram1[mem_addr_o[1]] <= mem_data_o[1];
        d1_1 <= ram1[mem_addr_o[1]];
        d1_2 <= d1_1;
    end
    assign ret_data_i[0] = ram0[mem_addr_o[0]];
    assign ret_data_i[1] = d1_2;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predicts the post-edge outputs from the inputs present now, then checks both DUTs.
    task automatic tick();
        pend_t p;
        int    w;
        logic  wr, blocked;
        logic [10:0] a;
        logic [15:0] d;
        n_edge++;
        last_gnt = 2;
        if (!rst_n) begin
            e_gnt0 = 0; e_gnt1 = 0; e_we = 0; e_prot = 0;
            e_maddr = '0; e_mdata = '0;
            m_last = 1; next_free = n_edge + 1;
            for (int i = 0; i < 2; i++) begin
                e_rv0[i] = 0; e_rv1[i] = 0; e_rd0[i] = '0; e_rd1[i] = '0;
            end
            pq0.delete();
            pq1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_rv0[i] = 0;
                e_rv1[i] = 0;
            end
            if (pq0.size() > 0 && pq0[0].due == n_edge) begin
                p = pq0.pop_front();
                if (p.port == 0) begin e_rv0[0] = 1; e_rd0[0] = p.data; end
                else             begin e_rv1[0] = 1; e_rd1[0] = p.data; end
            end
            if (pq1.size() > 0 && pq1[0].due == n_edge) begin
                p = pq1.pop_front();
                if (p.port == 0) begin e_rv0[1] = 1; e_rd0[1] = p.data; end
                else             begin e_rv1[1] = 1; e_rd1[1] = p.data; end
            end
            e_gnt0 = 0; e_gnt1 = 0; e_we = 0;
            if (n_edge >= next_free && (req0 || req1)) begin
                w  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
                wr = (w == 1) ? we1 : we0;
                a  = (w == 1) ? addr1 : addr0;
                d  = (w == 1) ? wdata1 : wdata0;
                blocked = PROT && (w == 0) && wr && (a >= 11'h780);
                if (w == 0) e_gnt0 = 1; else e_gnt1 = 1;
                e_maddr = a;
                e_mdata = d;
                e_we = wr && !blocked;
                if (blocked) e_prot = 1;
                m_last = w;
                next_free = n_edge + 2;
                last_gnt = w;
                if (!wr) begin
                    pq0.push_back('{due: n_edge + 1, port: w, data: mmem[a]});
                    pq1.push_back('{due: n_edge + 3, port: w, data: mmem[a]});
                end else if (!blocked) begin
                    mmem[a] = d;
                end
            end
        end
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("u%0d.gnt0", i), gnt0_o[i], e_gnt0);
            check_val($sformatf("u%0d.gnt1", i), gnt1_o[i], e_gnt1);
            check_val($sformatf("u%0d.we", i), we_o[i], e_we);
            check_val($sformatf("u%0d.mem_addr", i), mem_addr_o[i], e_maddr);
            check_val($sformatf("u%0d.mem_data", i), mem_data_o[i], e_mdata);
            check_val($sformatf("u%0d.rvalid0", i), rvalid0_o[i], e_rv0[i]);
            check_val($sformatf("u%0d.rvalid1", i), rvalid1_o[i], e_rv1[i]);
            check_val($sformatf("u%0d.rdata0", i), rdata0_o[i], e_rd0[i]);
            check_val($sformatf("u%0d.rdata1", i), rdata1_o[i], e_rd1[i]);
            check_val($sformatf("u%0d.prot_hit", i), prot_o[i], e_prot);
        end
    endtask

    function automatic logic [10:0] rand_addr();
        logic [10:0] r;
        if ($urandom % 4 == 0) r = 11'h780 + 11'($urandom % 128);
        else                   r = 11'($urandom % 32);
        return r;
    endfunction

    task automatic new_req(input int port);
        if (port == 0) begin
            req0 = 1; we0 = 1'($urandom); addr0 = rand_addr(); wdata0 = 16'($urandom);
        end else begin
            req1 = 1; we1 = 1'($urandom); addr1 = rand_addr(); wdata1 = 16'($urandom);
        end
    endtask

    initial begin
        rst_n = 0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;

        // Preload RAM and model while held in reset.
        pre_en = 1;
        for (int a = 0; a < 2048; a++) begin
            pre_a = 11'(a);
            case (a)
                'h010:   pre_d = 16'h1F20;
                'h001:   pre_d = 16'hA001;
                'h002:   pre_d = 16'hB002;
                default: pre_d = 16'($urandom);
            endcase
            mmem[a] = pre_d;
            @(posedge sys_clk);
            #1;
        end
        pre_en = 0;
        tick();
        tick();

        // Single port-0 write.
        rst_n = 1;
        req0 = 1; we0 = 1; addr0 = 11'h005; wdata0 = 16'h0741;
        tick();
        check_val("A.gnt0", gnt0_o[0], 1);
        check_val("A.we", we_o[0], 1);
        check_val("A.mem_addr", mem_addr_o[0], 11'h005);
        check_val("A.mem_data", mem_data_o[0], 16'h0741);
        req0 = 0;
        tick();
        check_val("A.we_clr", we_o[0], 0);
        tick();

        // Simultaneous writes from reset, both held: alternate starting with port 0.
        rst_n = 0;
        tick();
        rst_n = 1;
        req0 = 1; we0 = 1; addr0 = 11'h020; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 11'h021; wdata1 = 16'h2222;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_val($sformatf("B.gnt0.%0d", k), gnt0_o[0], (k % 4 == 1));
            check_val($sformatf("B.gnt1.%0d", k), gnt1_o[0], (k % 4 == 3));
        end
        req0 = 0; req1 = 0;
        tick();

        // Port-1 read of 0x010.
        req1 = 1; we1 = 0; addr1 = 11'h010;
        tick();
        req1 = 0;
        tick();
        check_val("C.rvalid1", rvalid1_o[0], 1);
        check_val("C.rdata1", rdata1_o[0], 16'h1F20);
        check_val("C.rvalid0", rvalid0_o[0], 0);
        tick();
        tick();

        // Back-to-back reads; the latency-3 instance returns them two cycles apart.
        req0 = 1; we0 = 0; addr0 = 11'h001;
        req1 = 1; we1 = 0; addr1 = 11'h002;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) req0 = 0;
            if (k == 3) req1 = 0;
            if (k == 4) begin
                check_val("D.rvalid0", rvalid0_o[1], 1);
                check_val("D.rdata0", rdata0_o[1], 16'hA001);
            end
            if (k == 6) begin
                check_val("D.rvalid1", rvalid1_o[1], 1);
                check_val("D.rdata1", rdata1_o[1], 16'hB002);
            end
        end

        // Reset in the cycle after a read grant cancels the return.
        req1 = 1; we1 = 0; addr1 = 11'h002;
        tick();
        req1 = 0;
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("E.rvalid1_l1", rvalid1_o[0], 0);
            check_val("E.rvalid1_l3", rvalid1_o[1], 0);
        end
        req0 = 1; we0 = 1; addr0 = 11'h030; wdata0 = 16'h3333;
        req1 = 1; we1 = 1; addr1 = 11'h031; wdata1 = 16'h4444;
        tick();
        check_val("E.tie_gnt0", gnt0_o[0], 1);
        req0 = 0; req1 = 0;
        tick();

        // Protected-row write from port 0, then port 1 to the same word.
        req0 = 1; we0 = 1; addr0 = 11'h780; wdata0 = 16'h5555;
        tick();
        check_val("F.gnt0", gnt0_o[0], 1);
        check_val("F.we0", we_o[0], !PROT);
        check_val("F.prot", prot_o[0], PROT);
        req0 = 0;
        tick();
        req1 = 1; we1 = 1; addr1 = 11'h780; wdata1 = 16'h6666;
        tick();
        check_val("F.gnt1", gnt1_o[0], 1);
        check_val("F.we1", we_o[0], 1);
        req1 = 0;
        tick();

        // Random traffic with withdrawals and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom % 100 != 0);
            if (last_gnt == 0) req0 = 0;
            if (last_gnt == 1) req1 = 0;
            if (!req0 && ($urandom % 3 == 0)) new_req(0);
            else if (req0 && ($urandom % 10 == 0)) req0 = 0;
            if (!req1 && ($urandom % 3 == 0)) new_req(1);
            else if (req1 && ($urandom % 10 == 0)) req1 = 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
